// File: rtl/pwm_fade_driver.sv
// Multi-channel PWM LED driver with a shared prescaler and PWM counter.
// Active duties change only at period boundaries, optionally ramping toward target.
module pwm_fade_driver #(
  parameter int CHANNELS   = 3,
  parameter int R          = 8,
  parameter int TIMER_BITS = 8,
  parameter int FADE_BITS  = 8,
  parameter int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] final_value,
  input  logic                  wr_en,
  input  logic [CH_BITS-1:0]    wr_chan,
  input  logic [R:0]            wr_duty,
  input  logic                  fade_en,
  input  logic [FADE_BITS-1:0]  fade_periods,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick,
  output logic                  busy
);

  localparam logic [R:0]   FULL    = {1'b1, {R{1'b0}}};
  localparam logic [R-1:0] CNT_MAX = '1;

  logic [TIMER_BITS-1:0] presc;
  logic [R-1:0]          pwm_cnt;
  logic [FADE_BITS-1:0]  fade_cnt;
  logic [R:0]            target [CHANNELS];
  logic [R:0]            active [CHANNELS];

  logic       tick;
  logic       boundary;
  logic       fade_step;
  logic [R:0] wr_clamped;

  assign tick       = enable && (presc == final_value);
  assign boundary   = tick && (pwm_cnt == CNT_MAX);
  assign fade_step  = (fade_cnt == fade_periods);
  assign wr_clamped = (wr_duty > FULL) ? FULL : wr_duty;

  // Prescaler: free-running width wrap lets a lowered terminal count recover.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (enable) begin
      if (tick) presc <= '0;
      else      presc <= presc + 1'b1;
    end
  end

  // PWM counter advances on every prescaler tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // One-cycle pulse following each period boundary edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) period_tick <= 1'b0;
    else          period_tick <= boundary;
  end

  // Fade counter counts boundaries, cleared whenever fading is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fade_cnt <= '0;
    end else if (!fade_en) begin
      fade_cnt <= '0;
    end else if (boundary) begin
      if (fade_step) fade_cnt <= '0;
      else           fade_cnt <= fade_cnt + 1'b1;
    end
  end

  // Target registers; out-of-range channels match no slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) target[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++)
        if (32'(wr_chan) == i) target[i] <= wr_clamped;
    end
  end

  // Active duty moves only at boundaries, jumping or stepping one LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
    end else if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!fade_en) begin
          active[i] <= target[i];
        end else if (fade_step) begin
          if (active[i] < target[i])      active[i] <= active[i] + 1'b1;
          else if (active[i] > target[i]) active[i] <= active[i] - 1'b1;
        end
      end
    end
  end

  // Registered compare; a full-scale duty exceeds every count value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= enable && ({1'b0, pwm_cnt} < active[i]);
    end
  end

  // Busy while any channel has not yet reached its target.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (active[i] != target[i]) busy = 1'b1;
  end

endmodule

// File: tb/tb_pwm_fade_driver.sv
// Randomized bench for pwm_fade_driver with a cycle model and literal spot checks.
// Outputs are compared on every falling edge.
module tb_pwm_fade_driver;

  localparam int CH  = 3;
  localparam int PER = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    final_value = '0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_chan = '0;
  logic [8:0]    wr_duty = '0;
  logic          fade_en = 1'b0;
  logic [7:0]    fade_periods = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;

  int m_pre, m_pwm, m_fc;
  int m_tgt [CH];
  int m_act [CH];
  bit m_out [CH];
  bit m_ptick;

  pwm_fade_driver dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .final_value(final_value), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_duty(wr_duty), .fade_en(fade_en), .fade_periods(fade_periods),
    .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: period of PER ticks, each tick every final_value+1 enabled cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pre = 0; m_pwm = 0; m_fc = 0; m_ptick = 0;
      for (int i = 0; i < CH; i++) begin
        m_tgt[i] = 0; m_act[i] = 0; m_out[i] = 0;
      end
    end else begin
      bit tk, bd, step;
      int d;
      tk = enable && (m_pre == int'(final_value));
      bd = tk && (m_pwm == PER - 1);
      step = (m_fc == int'(fade_periods));
      for (int i = 0; i < CH; i++) m_out[i] = enable && (m_pwm < m_act[i]);
      m_ptick = bd;
      if (bd) begin
        for (int i = 0; i < CH; i++) begin
          if (!fade_en) m_act[i] = m_tgt[i];
          else if (step && m_act[i] < m_tgt[i]) m_act[i]++;
          else if (step && m_act[i] > m_tgt[i]) m_act[i]--;
        end
      end
      if (!fade_en) m_fc = 0;
      else if (bd) m_fc = step ? 0 : m_fc + 1;
      if (wr_en && int'(wr_chan) < CH) begin
        d = int'(wr_duty);
        m_tgt[wr_chan] = (d > PER) ? PER : d;
      end
      if (enable) m_pre = tk ? 0 : (m_pre + 1) % 256;
      if (tk) m_pwm = (m_pwm + 1) % PER;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int exp_out;
    bit exp_busy;
    exp_out = 0;
    exp_busy = 0;
    for (int i = 0; i < CH; i++) begin
      if (m_out[i]) exp_out |= (1 << i);
      if (m_act[i] != m_tgt[i]) exp_busy = 1;
    end
    chk("pwm_out", int'(pwm_out), exp_out);
    chk("period_tick", int'(period_tick), int'(m_ptick));
    chk("busy", int'(busy), int'(exp_busy));
  end

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1;
    wr_chan = ch[1:0];
    wr_duty = d[8:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pt(input int lim, output int cyc);
    cyc = -1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (period_tick) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) chk("period_tick_timeout", 0, 1);
  endtask

  initial begin
    int c, cnt, fv_cnt;
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_period_tick", int'(period_tick), 0);
    reset_n = 1'b1;
    enable = 1'b1;

    wait_pt(600, c);
    wait_pt(600, c);
    chk("period_len", c, 256);

    repeat (37) @(negedge clk);
    wr(0, 64);
    chk("busy_after_write", int'(busy), 1);
    wait_pt(600, c);
    chk("busy_after_boundary", int'(busy), 0);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out[0]) cnt++;
    end
    chk("ch0_high_count", cnt, 64);

    wr(1, 256);
    wait_pt(600, c);
    wr(1, 300);
    wait_pt(600, c);
    wait_pt(600, c);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!pwm_out[1]) cnt++;
    end
    chk("ch1_full_low_count", cnt, 0);
    wr(1, 0);
    wait_pt(600, c);

    wait_pt(600, c);
    fade_en = 1'b1;
    fade_periods = 8'd1;
    wr(2, 4);
    cnt = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (period_tick) cnt++;
      if (!busy) break;
    end
    chk("fade_up_boundaries", cnt, 8);
    wr(2, 0);
    cnt = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (period_tick) cnt++;
      if (!busy) break;
    end
    chk("fade_down_boundaries", cnt, 8);

    fade_en = 1'b0;
    wait_pt(600, c);
    repeat (255) @(negedge clk);
    wr(0, 200);
    chk("coincident_tick", int'(period_tick), 1);
    chk("coincident_busy", int'(busy), 1);
    wait_pt(600, c);
    chk("coincident_applied", int'(busy), 0);
    wr(3, 100);
    chk("bad_chan_busy", int'(busy), 0);

    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_out", int'(pwm_out), 0);
    repeat (99) @(negedge clk);
    enable = 1'b1;
    repeat (300) @(negedge clk);

    fade_en = 1'b1;
    fade_periods = 8'd0;
    wr(1, 200);
    wait_pt(600, c);
    wait_pt(600, c);
    chk("mid_fade_busy", int'(busy), 1);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out", int'(pwm_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;

    fv_cnt = 0;
    for (int k = 0; k < 6000; k++) begin
      enable  = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_chan = 2'($urandom_range(0, 3));
      wr_duty = 9'($urandom_range(0, 299));
      if ($urandom_range(0, 199) == 0) fade_en = ~fade_en;
      if ($urandom_range(0, 299) == 0)
        fade_periods = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0 && fv_cnt < 4) begin
        final_value = 8'($urandom_range(0, 2));
        fv_cnt++;
      end
      @(negedge clk);
      if (k == 3000) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    wr_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_driver.md
Name: pwm_fade_driver

Overview:
- Multi-channel PWM LED driver, successor to the fixed three-channel RGB driver. Generalised to CHANNELS outputs that share one prescaler and one PWM counter.
- Each channel has a write-addressed target duty. The active duty is updated only at PWM period boundaries, so outputs never glitch.
- Optional fade mode ramps each active duty one LSB per N periods toward its target.
- Sits between a register or control FSM and the board LED pins.

Parameters:
CHANNELS, 3, number of PWM outputs (>=1)
R, 8, PWM counter width; duty is R+1 bits so 2^R means 100%
TIMER_BITS, 8, prescaler counter width
FADE_BITS, 8, fade-rate counter width
CH_BITS, $clog2(CHANNELS) (min 1), channel-index width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run; 0 freezes counters and forces outputs low
final_value  in  TIMER_BITS  prescaler terminal count; tick every final_value+1 enabled cycles
wr_en  in  1  target-duty write strobe, single cycle
wr_chan  in  CH_BITS  channel index for write
wr_duty  in  R+1  target duty value
fade_en  in  1  1 = ramp active duty toward target; 0 = jump to target
fade_periods  in  FADE_BITS  fade rate: one step per fade_periods+1 PWM periods
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-cycle pulse at each PWM period boundary
busy  out  1  1 while any active duty differs from its target

Behaviour:
- Reset (async assert, sync release): all counters, targets and active duties are 0; pwm_out=0, period_tick=0, busy=0.
- Prescaler:
  - Counts 0..final_value while enable=1. Asserts an internal tick and returns to 0 when count==final_value.
  - final_value=0 gives a tick every enabled cycle.
  - final_value changed below the current count: counter continues to wrap at 2^TIMER_BITS-1 and then uses the new value.
- PWM counter:
  - R bits; increments on each tick and wraps 2^R-1 -> 0.
  - Boundary = tick while PWM counter == 2^R-1.
  - period_tick is registered and high for exactly the cycle after the boundary edge.
- Output compare:
  - pwm_out[i] is registered: pwm_out[i] <= enable & (pwm_cnt < active[i]). This gives one cycle latency from the counter.
  - active=0 gives constant low. active>=2^R gives constant high with no gap at the wrap.
- enable=0:
  - Prescaler, PWM counter and fade counter hold their values.
  - pwm_out goes to 0 on the next edge.
  - Writes are still accepted.
  - Resumes from the held count when enable returns to 1.
- Write:
  - wr_en=1 with wr_chan<CHANNELS sets target[wr_chan] at that edge.
  - wr_duty > 2^R is clamped to 2^R.
  - wr_chan >= CHANNELS is ignored with no side effect.
- Active-duty update happens only on boundary edges and uses target values as registered before that edge. A write coinciding with a boundary takes effect at the following boundary.
  - fade_en=0: active[i] <= target[i] for all channels.
  - fade_en=1:
    - Shared fade counter counts boundaries 0..fade_periods.
    - On the boundary where the count equals fade_periods, each active[i] steps +1 or -1 toward target[i] (no change if equal), and the counter returns to 0.
    - The counter resets to 0 whenever fade_en=0.
  - fade_en cleared mid-fade: the next boundary jumps all channels to target.
- busy is combinational OR over channels of (active[i] != target[i]).
  - Goes high the cycle after a differing write.
  - Goes low the cycle after the boundary edge that equalises the last channel.
- Reset asserted mid-fade: immediate return to reset state; no partial ramp is retained.

Test Plan:
1. Setup CHANNELS=3, R=8, final_value=0. Assert and release reset -> pwm_out=000, busy=0, period_tick pulses every 256 cycles once enable=1.
2. fade_en=0; write ch0=64 mid-period -> busy=1; pwm_out[0] stays 0 until the next boundary, then high 64 of every 256 cycles; busy=0 after that boundary.
3. Write ch1=256 -> pwm_out[1] constant high with no low cycle at the wrap. Write ch1=300 -> same as 256. Write ch1=0 -> constant low after the next boundary.
4. fade_en=1, fade_periods=1, write ch2=4 from 0 -> active increments at every 2nd boundary and reaches 4 after 8 boundaries; busy falls then. Write ch2=0 -> decrements over 8 boundaries.
5. Write coincident with a boundary edge -> old target applied at that boundary, new target at the next. wr_chan=3 -> no target changes, busy unchanged.
6. Drop enable for 100 cycles mid-period -> pwm_out=0 the next cycle, counters frozen, phase resumes exactly. Assert reset mid-fade -> all state returns to 0.
